// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 32-bit ALU: issues each accepted command for one clock,
// parks the ALU on the feedback opcode otherwise, and queues results in a response FIFO.
module alu_cmd_sequencer #(
    parameter int         W      = 32,
    parameter int         DEPTH  = 4,
    parameter logic [3:0] NOP_OP = 4'b1110
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    output logic [W-1:0] alu_p,
    output logic [W-1:0] alu_q,
    output logic [3:0]   alu_op,
    input  logic [W-1:0] alu_result,
    input  logic [1:0]   alu_err,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic [1:0]   rsp_err,
    output logic [3:0]   rsp_op,
    output logic [7:0]   err_count
);

    localparam int            AW     = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_C = (AW + 1)'(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    state_t         state_q;
    logic [3:0]     alu_op_q;
    logic [W-1:0]   alu_p_q;
    logic [W-1:0]   alu_q_q;
    logic [7:0]     err_count_q;

    logic [W-1:0]   mem_data_q [DEPTH];
    logic [1:0]     mem_err_q  [DEPTH];
    logic [3:0]     mem_op_q   [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    count_q;
    logic [AW:0]    count_d;

    logic           push_s;
    logic           pop_s;

    assign cmd_ready = rst_n && (state_q == ST_IDLE) && (count_q < FULL_C);
    assign push_s    = (state_q == ST_EXEC);
    assign pop_s     = (count_q != {(AW + 1){1'b0}}) && rsp_ready;

    // Sequencer FSM: latch an accepted command onto the ALU ports for exactly one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            alu_op_q    <= NOP_OP;
            alu_p_q     <= {W{1'b0}};
            alu_q_q     <= {W{1'b0}};
            err_count_q <= 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state_q  <= ST_EXEC;
                        alu_op_q <= cmd_op;
                        alu_p_q  <= cmd_a;
                        alu_q_q  <= cmd_b;
                    end else begin
                        state_q  <= ST_IDLE;
                        alu_op_q <= NOP_OP;
                    end
                end
                ST_EXEC: begin
                    // Operands are left in place so the ALU inputs do not toggle while parked
                    state_q  <= ST_IDLE;
                    alu_op_q <= NOP_OP;
                    if ((alu_err != 2'b00) && (err_count_q != 8'hFF)) begin
                        err_count_q <= err_count_q + 8'd1;
                    end else begin
                        err_count_q <= err_count_q;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    alu_op_q <= NOP_OP;
                end
            endcase
        end
    end

    // FIFO occupancy next-state
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Response FIFO storage and pointers; space for the push was reserved at accept time
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW + 1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= {W{1'b0}};
                mem_err_q[i]  <= 2'b00;
                mem_op_q[i]   <= 4'b0000;
            end
        end else begin
            if (push_s) begin
                mem_data_q[wr_ptr_q] <= alu_result;
                mem_err_q[wr_ptr_q]  <= alu_err;
                mem_op_q[wr_ptr_q]   <= alu_op_q;
                wr_ptr_q             <= wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign alu_op    = alu_op_q;
    assign alu_p     = alu_p_q;
    assign alu_q     = alu_q_q;
    assign rsp_valid = (count_q != {(AW + 1){1'b0}});
    assign rsp_data  = mem_data_q[rd_ptr_q];
    assign rsp_err   = mem_err_q[rd_ptr_q];
    assign rsp_op    = mem_op_q[rd_ptr_q];
    assign err_count = err_count_q;

endmodule
